serial_parity_framer: RTL and testbench

//   Multi-channel serial parity tracker, successor to the single-bit odd/even detector.

---
 rtl/serial_parity_framer_if.sv | 28 ++
 rtl/serial_parity_framer.sv | 72 +++++++
 tb/tb_serial_parity_framer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_framer_if.sv
// Bit-stream and frame-result signals of the multi-lane serial parity framer.
// Handshake: a bit column x is taken on any rising edge where in_valid=1 and
// clear=0; there is no back-pressure, and frame_valid is a one-cycle strobe.
interface serial_parity_framer_if #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8
);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic                clear;
    logic                in_valid;
    logic [CHANNELS-1:0] x;
    logic                odd_sel;
    logic [CHANNELS-1:0] result;
    logic [CHANNELS-1:0] frame_parity;
    logic                frame_valid;
    logic [CNT_W-1:0]    bit_cnt;

    modport master (
        output clear, in_valid, x, odd_sel,
        input  result, frame_parity, frame_valid, bit_cnt
    );

    modport slave (
        input  clear, in_valid, x, odd_sel,
        output result, frame_parity, frame_valid, bit_cnt
    );
endinterface

// File: rtl/serial_parity_framer.sv
// Per-lane running parity over serial bits, closed into FRAME_LEN-bit frames
// with a selectable even/odd sense latched at the start of each frame.
module serial_parity_framer #(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_parity_framer_if.slave bus
);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [CHANNELS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0] fpar_q, fpar_d;
    logic                fvalid_q, fvalid_d;
    logic                mode_q, mode_d;
    logic                accept;

    assign accept = bus.in_valid & ~bus.clear;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        fpar_d   = fpar_q;
        fvalid_d = 1'b0;
        mode_d   = mode_q;

        // The sense is only re-sampled between frames, including the cycle
        // that accepts the first bit of a new frame.
        if (cnt_q == '0) begin
            mode_d = bus.odd_sel;
        end

        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (cnt_q == LAST_CNT) begin
                fpar_d   = acc_q ^ bus.x ^ {CHANNELS{mode_q}};
                fvalid_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = acc_q ^ bus.x;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            fpar_q   <= '0;
            fvalid_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fpar_q   <= fpar_d;
            fvalid_q <= fvalid_d;
            mode_q   <= mode_d;
        end
    end

    assign bus.result       = acc_q ^ {CHANNELS{mode_q}};
    assign bus.frame_parity = fpar_q;
    assign bus.frame_valid  = fvalid_q;
    assign bus.bit_cnt      = cnt_q;
endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench for serial_parity_framer with two lanes and 4-bit frames.
module tb_serial_parity_framer;
    localparam int CH = 2;
    localparam int FL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_parity_framer_if #(.CHANNELS(CH), .FRAME_LEN(FL)) bus ();

    serial_parity_framer #(.CHANNELS(CH), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [CH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 carries b, lane 1 carries ~b.
    task automatic send(input logic b);
        bus.x        = {~b, b};
        bus.in_valid = 1'b1;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_result"}, 32'(bus.result), 32'h0);
        check_eq({tag, "_fpar"}, 32'(bus.frame_parity), 32'h0);
        check_eq({tag, "_fvalid"}, 32'(bus.frame_valid), 32'h0);
        check_eq({tag, "_cnt"}, 32'(bus.bit_cnt), 32'h0);
    endtask

    logic [0:11] b2b_bits;
    logic [0:2]  b2b_modes;
    logic [CH-1:0] run_par;
    logic [CH-1:0] got;
    int pulses;

    initial begin
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.odd_sel  = 1'b0;

        // Reset held across the first edge
        #12;
        check_zero("rst");
        rst_n = 1'b1;
        tick();

        // Even frame: lane0 0,1,0,0  lane1 1,0,1,1
        bus.odd_sel = 1'b0;
        send(1'b0);
        check_eq("even_r0", 32'(bus.result), 32'h2);
        check_eq("even_c0", 32'(bus.bit_cnt), 32'h1);
        send(1'b1);
        check_eq("even_r1", 32'(bus.result), 32'h3);
        send(1'b0);
        check_eq("even_r2", 32'(bus.result), 32'h1);
        check_eq("even_c2", 32'(bus.bit_cnt), 32'h3);
        check_eq("even_fv_early", 32'(bus.frame_valid), 32'h0);
        send(1'b0);
        check_eq("even_fv", 32'(bus.frame_valid), 32'h1);
        check_eq("even_fp", 32'(bus.frame_parity), 32'h3);
        check_eq("even_cnt_wrap", 32'(bus.bit_cnt), 32'h0);
        check_eq("even_r_wrap", 32'(bus.result), 32'h0);

        // Odd frame: lane0 1,1,0,1  lane1 0,0,1,0
        bus.odd_sel = 1'b1;
        send(1'b1);
        check_eq("odd_fv_drop", 32'(bus.frame_valid), 32'h0);
        check_eq("odd_r0", 32'(bus.result), 32'h2);
        send(1'b1);
        check_eq("odd_r1", 32'(bus.result), 32'h3);
        send(1'b0);
        check_eq("odd_r2", 32'(bus.result), 32'h1);
        send(1'b1);
        check_eq("odd_fv", 32'(bus.frame_valid), 32'h1);
        check_eq("odd_fp", 32'(bus.frame_parity), 32'h0);

        // Mode change mid-frame is ignored until the next frame
        bus.odd_sel = 1'b0;
        send(1'b0);
        send(1'b0);
        bus.odd_sel = 1'b1;
        send(1'b0);
        check_eq("mode_r2", 32'(bus.result), 32'h2);
        send(1'b0);
        check_eq("mode_fp0", 32'(bus.frame_parity), 32'h0);
        check_eq("mode_fv0", 32'(bus.frame_valid), 32'h1);
        for (int i = 0; i < 4; i++) send(1'b0);
        check_eq("mode_fp1", 32'(bus.frame_parity), 32'h3);
        check_eq("mode_fv1", 32'(bus.frame_valid), 32'h1);

        // Stall after two bits: state holds, no early frame
        bus.odd_sel = 1'b0;
        send(1'b1);
        send(1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_cnt", 32'(bus.bit_cnt), 32'h2);
            check_eq("stall_fv", 32'(bus.frame_valid), 32'h0);
            check_eq("stall_r", 32'(bus.result), 32'h3);
        end
        send(1'b1);
        send(1'b1);
        check_eq("stall_fv_end", 32'(bus.frame_valid), 32'h1);
        check_eq("stall_fp", 32'(bus.frame_parity), 32'h3);

        // Three back-to-back frames, expected parity kept in a queue
        b2b_bits  = 12'b1110_0110_1000;
        b2b_modes = 3'b011;
        pulses    = 0;
        run_par   = '0;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) begin
                bus.odd_sel = b2b_modes[i/4];
                run_par     = '0;
            end
            run_par = run_par ^ {~b2b_bits[i], b2b_bits[i]};
            if (i % 4 == 3) exp_q.push_back(run_par ^ {CH{b2b_modes[i/4]}});
            send(b2b_bits[i]);
            check_eq("b2b_fv", 32'(bus.frame_valid), 32'(i % 4 == 3));
            if (bus.frame_valid) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check_eq("b2b_fp", 32'(bus.frame_parity), 32'(got));
                end else begin
                    check_eq("b2b_unexpected_fv", 32'h1, 32'h0);
                end
            end
        end
        check_eq("b2b_pulses", 32'(pulses), 32'd3);
        check_eq("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Clear wins over a closing bit; frame_parity keeps 00
        bus.odd_sel = 1'b0;
        send(1'b1);
        send(1'b1);
        send(1'b0);
        check_eq("clr_pre_cnt", 32'(bus.bit_cnt), 32'h3);
        bus.clear = 1'b1;
        send(1'b1);
        bus.clear = 1'b0;
        check_eq("clr_cnt", 32'(bus.bit_cnt), 32'h0);
        check_eq("clr_fv", 32'(bus.frame_valid), 32'h0);
        check_eq("clr_fp", 32'(bus.frame_parity), 32'h0);
        check_eq("clr_r", 32'(bus.result), 32'h0);

        // Asynchronous reset mid-cycle, partway through a frame
        send(1'b1);
        send(1'b0);
        check_eq("arst_pre_cnt", 32'(bus.bit_cnt), 32'h2);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("arst_idle_fv", 32'(bus.frame_valid), 32'h0);

        // Full frame after reset: lane0 1,0,1,1  lane1 0,1,0,0, even
        bus.odd_sel = 1'b0;
        send(1'b1);
        check_eq("post_fv0", 32'(bus.frame_valid), 32'h0);
        send(1'b0);
        send(1'b1);
        check_eq("post_cnt", 32'(bus.bit_cnt), 32'h3);
        send(1'b1);
        check_eq("post_fv", 32'(bus.frame_valid), 32'h1);
        check_eq("post_fp", 32'(bus.frame_parity), 32'h3);
        bus.in_valid = 1'b0;
        tick();
        check_eq("post_fv_drop", 32'(bus.frame_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
